multiword_add_sub_seq: RTL
==========================

// Module: multiword_add_sub_seq
// PURPOSE
//  Sequential multi-precision adder/subtractor upstream of the ripple_carry_adder datapath.
//  Accepts W = NUM_WORDS*DATA_WIDTH-bit operands and feeds one DATA_WIDTH slice per cycle (LS first) into the adder.
//  Registers the adder's carry back into C0 for the next slice, and collects slice sums into a full-width result.
//  Presents the result with CF/OF via a valid/ready handshake.
// PARAMETERS
//  DATA_WIDTH  4  width of one adder slice (bits)
//  NUM_WORDS   4  slices per operand; W = NUM_WORDS*DATA_WIDTH; must be >= 2
// PORTS
//  CLK        in   1  single clock, rising edge
//  RST        in   1  reset: asynchronous, active-high
//  IN_VALID   in   1  operand request valid
//  IN_READY   out  1  block can accept operands this cycle
//  A          in   W  operand A (two's complement / unsigned)
//  B          in   W  operand B
//  SUB        in   1  0: A+B, 1: A-B
//  OUT_VALID  out  1  S/CF/OF valid, held until OUT_READY
//  OUT_READY  in   1  consumer accepts result
//  S          out  W  result
//  CF         out  1  carry out of MS slice (SUB: 1 = no borrow)
//  OF         out  1  signed overflow (adder OF of MS slice)
// BEHAVIOUR
//  - Reset (async, RST=1): state IDLE, IN_READY=1, OUT_VALID=0, S=0, CF=0, OF=0, slice index=0, carry reg=0.
//  - Clock/reset: one clock, CLK; RST is asynchronous and active-high.
//  - FSM: IDLE -> RUN -> DONE.
//  - IDLE: IN_READY=1. On IN_VALID&IN_READY edge: latch A, B (B inverted when SUB), carry reg=SUB, index=0; go RUN.
//  - RUN: IN_READY=0. Each edge: S[idx slice] <= adder sum; carry reg <= adder CF; idx++.
//  - RUN exit: on the edge processing idx=NUM_WORDS-1, latch CF, OF from the adder; go DONE.
//  - Adder inputs in RUN: A slice, (possibly inverted) B slice, C0 = carry reg. Purely combinational; no extra latency.
//  - Latency: OUT_VALID rises exactly NUM_WORDS cycles after the accepting edge.
//  - DONE: OUT_VALID=1; S/CF/OF stable while OUT_READY=0 (backpressure, unbounded).
//  - DONE, OUT_READY=1: result consumed that edge; IN_READY=1 in the same cycle (back-to-back).
//  - DONE handoff, IN_VALID=1: new operands are accepted; go RUN.
//  - DONE handoff, IN_VALID=0: go IDLE.
//  - S/CF/OF retain the last result after consumption until overwritten by a new operation's slices.
//  - IN_VALID during RUN, or DONE without OUT_READY: ignored; inputs not sampled.
//  - Wrap-around: index counts 0..NUM_WORDS-1 only; result wraps modulo 2^W; the carry beyond W is reported only in CF.
//  - RST mid-RUN or mid-DONE: operation aborted, no OUT_VALID pulse, all outputs return to reset values.
// CONFIGURATION
//  ADDSUB_ZERO_FLAG_EN defined:
//   - Adds port ZF (out, 1): 1 when the final S == 0. ZF is 0 on reset.
//   - ZF is computed incrementally as the AND of per-slice zero checks and latched with CF/OF.
//  ADDSUB_ZERO_FLAG_EN undefined: no ZF port and no zero logic; all other behaviour identical.
// STRUCTURE
//  - Shared package: FSM state typedef (IDLE/RUN/DONE) and the index width constant $clog2(NUM_WORDS).
//  - Sub-module: one ripple_carry_adder #(DATA_WIDTH) instance as the slice datapath.
//  - FSM, index counter, carry register and result register live in this module.
// TESTING  (DATA_WIDTH=4, NUM_WORDS=2, W=8)
//  - ADD 0x15+0x27, OUT_READY=1 -> OUT_VALID 2 cycles after accept; S=0x3C, CF=0, OF=0 (ZF=0).
//  - ADD 0x7F+0x01 -> S=0x80, CF=0, OF=1. ADD 0xFF+0x01 -> S=0x00, CF=1, OF=0 (ZF=1).
//  - SUB 0x05-0x07 -> S=0xFE, CF=0, OF=0. SUB 0x80-0x01 -> S=0x7F, CF=1, OF=1.
//  - Backpressure: OUT_READY=0 for 5 cycles -> S/CF/OF stable, IN_READY=0, new IN_VALID ignored.
//  - Back-to-back handoff: OUT_READY=1 and IN_VALID=1 in DONE -> new op accepted that edge; next OUT_VALID 2 cycles later.
//  - RST pulse during RUN (after slice 0) -> outputs zero, IDLE, no OUT_VALID.
//  - After that reset, the next op 0x15+0x27 -> S=0x3C (no stale carry).

Source files
------------

// File: rtl/multiword_add_sub_seq_pkg.sv
// Shared types and constants for the sequential multi-word adder/subtractor.
//   state_t   : control FSM encoding (IDLE / RUN / DONE)
//   idx_width : slice index width, $clog2(num_words), never narrower than one bit
package multiword_add_sub_seq_pkg;

   localparam int unsigned DEF_DATA_WIDTH = 4;
   localparam int unsigned DEF_NUM_WORDS  = 4;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   function automatic int unsigned idx_width(input int unsigned num_words);
      return (num_words > 1) ? $clog2(num_words) : 1;
   endfunction

endpackage

// File: rtl/multiword_add_sub_seq_rca.sv
// Purely combinational ripple-carry adder used as the per-slice datapath.
// Ports:
//   i_a, i_b [DATA_WIDTH] : addends
//   i_c0                  : carry in
//   o_s   [DATA_WIDTH]    : sum
//   o_cf                  : carry out of the MSB
//   o_of                  : signed overflow (carry into MSB xor carry out)
module ripple_carry_adder #(
   parameter int unsigned DATA_WIDTH = 4
) (
   input  logic [DATA_WIDTH-1:0] i_a,
   input  logic [DATA_WIDTH-1:0] i_b,
   input  logic                  i_c0,
   output logic [DATA_WIDTH-1:0] o_s,
   output logic                  o_cf,
   output logic                  o_of
);

   logic [DATA_WIDTH:0] w_c;

   assign w_c[0] = i_c0;

   // One full adder per bit, carry rippling upward.
   for (genvar g = 0; g < DATA_WIDTH; g++) begin : g_fa
      assign o_s[g]     = i_a[g] ^ i_b[g] ^ w_c[g];
      assign w_c[g + 1] = (i_a[g] & i_b[g]) | (i_a[g] & w_c[g]) | (i_b[g] & w_c[g]);
   end

   assign o_cf = w_c[DATA_WIDTH];
   assign o_of = w_c[DATA_WIDTH] ^ w_c[DATA_WIDTH - 1];

endmodule

// File: rtl/multiword_add_sub_seq.sv
// Sequential multi-precision adder/subtractor. Operands of W = NUM_WORDS*DATA_WIDTH
// bits are fed one slice per cycle (LS first) through a ripple_carry_adder, with the
// slice carry registered back into the next slice's carry-in.
// Ports:
//   CLK, RST (async, active-high)
//   IN_VALID / IN_READY  : operand handshake (A, B, SUB; SUB=1 computes A-B)
//   OUT_VALID / OUT_READY: result handshake (S, CF, OF)
//   ZF                   : final S == 0, present only with ADDSUB_ZERO_FLAG_EN defined
module multiword_add_sub_seq
   import multiword_add_sub_seq_pkg::*;
#(
   parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
   parameter int unsigned NUM_WORDS  = DEF_NUM_WORDS
) (
   input  logic                            CLK,
   input  logic                            RST,
   input  logic                            IN_VALID,
   output logic                            IN_READY,
   input  logic [NUM_WORDS*DATA_WIDTH-1:0] A,
   input  logic [NUM_WORDS*DATA_WIDTH-1:0] B,
   input  logic                            SUB,
   output logic                            OUT_VALID,
   input  logic                            OUT_READY,
   output logic [NUM_WORDS*DATA_WIDTH-1:0] S,
   output logic                            CF,
   output logic                            OF
`ifdef ADDSUB_ZERO_FLAG_EN
   ,output logic                           ZF
`endif
);

   localparam int unsigned W     = NUM_WORDS * DATA_WIDTH;
   localparam int unsigned IDX_W = idx_width(NUM_WORDS);

   state_t                r_state;
   state_t                w_next_state;
   logic [W-1:0]          r_a;
   logic [W-1:0]          r_b;
   logic                  r_carry;
   logic [IDX_W-1:0]      r_idx;
   logic [W-1:0]          r_s;
   logic                  r_cf;
   logic                  r_of;

   logic                  w_in_ready;
   logic                  w_accept;
   logic                  w_step;
   logic                  w_last;
   logic [DATA_WIDTH-1:0] w_sum;
   logic                  w_cf;
   logic                  w_of;

   // Operand registers shift right each step, so the active slice is always the LS one.
   ripple_carry_adder #(
      .DATA_WIDTH (DATA_WIDTH)
   ) u_rca (
      .i_a  (r_a[DATA_WIDTH-1:0]),
      .i_b  (r_b[DATA_WIDTH-1:0]),
      .i_c0 (r_carry),
      .o_s  (w_sum),
      .o_cf (w_cf),
      .o_of (w_of)
   );

   assign w_last = (r_idx == IDX_W'(NUM_WORDS - 1));

   // Next-state and handshake decode; DONE with OUT_READY reopens the input port.
   always_comb begin
      w_next_state = r_state;
      w_in_ready   = 1'b0;
      w_step       = 1'b0;
      case (r_state)
         ST_IDLE: begin
            w_in_ready = 1'b1;
            if (IN_VALID) w_next_state = ST_RUN;
         end
         ST_RUN: begin
            w_step = 1'b1;
            if (w_last) w_next_state = ST_DONE;
         end
         ST_DONE: begin
            if (OUT_READY) begin
               w_in_ready   = 1'b1;
               w_next_state = IN_VALID ? ST_RUN : ST_IDLE;
            end
         end
         default: w_next_state = ST_IDLE;
      endcase
   end

   assign w_accept = IN_VALID & w_in_ready;

   // State register.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) r_state <= ST_IDLE;
      else     r_state <= w_next_state;
   end

   // Operand, carry and index datapath.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         r_a     <= '0;
         r_b     <= '0;
         r_carry <= 1'b0;
         r_idx   <= '0;
      end else if (w_accept) begin
         r_a     <= A;
         r_b     <= SUB ? ~B : B;
         r_carry <= SUB;
         r_idx   <= '0;
      end else if (w_step) begin
         r_a     <= r_a >> DATA_WIDTH;
         r_b     <= r_b >> DATA_WIDTH;
         r_carry <= w_cf;
         r_idx   <= w_last ? '0 : r_idx + IDX_W'(1);
      end
   end

   // Result register: only the slice addressed by r_idx changes in a step.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         r_s  <= '0;
         r_cf <= 1'b0;
         r_of <= 1'b0;
      end else if (w_step) begin
         for (int k = 0; k < NUM_WORDS; k++) begin
            if (r_idx == IDX_W'(k)) r_s[k*DATA_WIDTH +: DATA_WIDTH] <= w_sum;
         end
         if (w_last) begin
            r_cf <= w_cf;
            r_of <= w_of;
         end
      end
   end

`ifdef ADDSUB_ZERO_FLAG_EN
   logic r_zacc;
   logic r_zf;

   // Running AND of per-slice zero checks, published with CF/OF on the last slice.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         r_zacc <= 1'b0;
         r_zf   <= 1'b0;
      end else if (w_accept) begin
         r_zacc <= 1'b1;
      end else if (w_step) begin
         r_zacc <= r_zacc & (w_sum == '0);
         if (w_last) r_zf <= r_zacc & (w_sum == '0);
      end
   end

   assign ZF = r_zf;
`endif

   assign IN_READY  = w_in_ready;
   assign OUT_VALID = (r_state == ST_DONE);
   assign S         = r_s;
   assign CF        = r_cf;
   assign OF        = r_of;

endmodule
